mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Access sequencer that sits directly upstream of the 8x8 memory array and drives its per-word `sel`, shared `rw` and data-in bus. Converts a single-beat valid/ready request (address, write flag, write data) into a fixed SETUP/STROBE sequence on the array, captures read data, and returns a response on a valid/ready channel. One outstanding request at a time.

## Interface
Parameters:
- `ADDR_W`, 3: word address width; array depth `NWORDS = 1 << ADDR_W`.
- `DATA_W`, 8: word width.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data (ignored on reads).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes.
- `rsp_err`  out  1  write-verify mismatch (0 when `MEM_CTRL_WVERIFY_EN` is undefined).
- `word_sel`  out  NWORDS  one-hot word select to array; bit n drives word n `sel`.
- `arr_rw`  out  1  array read/write: 1 = write, 0 = read.
- `arr_wdata`  out  DATA_W  data to all words' `i` bus.
- `arr_rdata`  in  DATA_W  OR-combined `o` bus from array.

## Operation
- FSM states: IDLE, SETUP, STROBE, SAMPLE, RESP (plus VSETUP, VSTROBE, VSAMPLE with `MEM_CTRL_WVERIFY_EN`).
- IDLE: `req_ready`=1. On `req_valid && req_ready`, the block latches addr/we/wdata and moves to SETUP.
- SETUP: `arr_rw` = latched we; `arr_wdata` = latched wdata (writes) or 0 (reads); `word_sel` = 0. Next: STROBE.
- STROBE: `word_sel` = one-hot(addr); `arr_rw` and `arr_wdata` unchanged from SETUP. Next: SAMPLE for reads; RESP for writes (VSETUP with verify).
- SAMPLE: `word_sel` stays asserted and `arr_rw`=0; the block registers `arr_rdata` into `rsp_rdata`. Next: RESP.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` stable until `rsp_valid && rsp_ready`, then IDLE. `word_sel`=0.
- `req_ready`=0 in every state except IDLE; requests are never dropped, only stalled.
- All array-side outputs are registered; `word_sel` is never multi-hot and is 0 outside STROBE/SAMPLE.
- `arr_rw` changes only in cycles where `word_sel`=0.

## Timing
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after it (IDLE); `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `word_sel`=0, `arr_rw`=0, `arr_wdata`=0; state IDLE.
- Accept in cycle T. SETUP is T+1 and STROBE is T+2.
  - Write: RESP from T+3.
  - Read: SAMPLE at T+3, RESP from T+4.
- `rsp_ready` held high gives a write throughput of 1 per 4 cycles and a read throughput of 1 per 5 cycles. The next accept is the cycle after the response handshake.
- `rsp_ready` may be high before `rsp_valid`; the handshake occurs in the first RESP cycle.
- Reset in any state: the next cycle is IDLE with reset values. An in-flight write may or may not have reached the array; the response is discarded.
- Address wrap: all `NWORDS` addresses are valid; there is no out-of-range case.

## Configuration
- `MEM_CTRL_WVERIFY_EN` defined:
  - After a write's STROBE, the block runs VSETUP (`arr_rw`=0, `word_sel`=0), then VSTROBE (select asserted), then VSAMPLE. VSAMPLE compares `arr_rdata` with the latched wdata and sets `rsp_err` on mismatch.
  - `rsp_rdata` returns the read-back value.
  - Write response arrives at T+6.
- `MEM_CTRL_WVERIFY_EN` undefined: no verify states; `rsp_err` is tied 0 and write response arrives at T+3.

## Structure
- Shared package `mem_ctrl_pkg`: FSM state enum, `ADDR_W`/`DATA_W` defaults, `RW_WRITE`=1 and `RW_READ`=0 constants.
- One sub-module, `addr_onehot_dec` (ADDR_W to NWORDS one-hot, combinational), feeding the `word_sel` register.

## Test plan
- Reset then idle: hold `rst` 2 cycles -> all outputs at reset values, `req_ready`=1 the cycle after release.
- Write addr 3, data 0xA5, `rsp_ready`=1:
  - `word_sel`=0x08 and `arr_rw`=1 and `arr_wdata`=0xA5 exactly at T+2.
  - `rsp_valid` at T+3, `rsp_err`=0.
- Read addr 3 with array model returning 0xA5 -> `word_sel`=0x08 at T+2..T+3 with `arr_rw`=0, `rsp_rdata`=0xA5 at T+4.
- Backpressure: read addr 7, `rsp_ready`=0 for 5 cycles -> `rsp_valid`, `rsp_rdata` stable, `req_ready`=0, a second `req_valid` stalled and accepted the cycle after the handshake.
- Reset asserted in STROBE of a write to addr 0 -> next cycle `word_sel`=0, `rsp_valid`=0, `req_ready`=1.
- With `MEM_CTRL_WVERIFY_EN`, array model stuck bit 0 low, write 0x01 to addr 5 -> `rsp_err`=1, `rsp_rdata`=0x00 at T+6.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: FSM states, default widths
// and array read/write encodings.
package mem_ctrl_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 8;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // The verify states exist in every build; they are only reached when write verify is on.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_SAMPLE  = 3'd3,
      ST_RESP    = 3'd4,
      ST_VSETUP  = 3'd5,
      ST_VSTROBE = 3'd6,
      ST_VSAMPLE = 3'd7
   } state_e;

endpackage

// File: rtl/addr_onehot_dec.sv
// Combinational word-address to one-hot word-select decoder.
module addr_onehot_dec #(
   parameter int ADDR_W = 3
) (
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [(1<<ADDR_W)-1:0] onehot_o
);

   localparam int NWORDS = 1 << ADDR_W;

   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_dec
      assign onehot_o[gi] = (addr_i == ADDR_W'(gi));
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding access sequencer for the 8x8 word array (SETUP/STROBE/SAMPLE).
// Define MEM_CTRL_WVERIFY_EN to read back and compare every write.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic [(1<<ADDR_W)-1:0]  word_sel,
   output logic                    arr_rw,
   output logic [DATA_W-1:0]       arr_wdata,
   input  logic [DATA_W-1:0]       arr_rdata
);

   localparam int NWORDS = 1 << ADDR_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [NWORDS-1:0]   word_sel_q, word_sel_d;
   logic                arr_rw_q, arr_rw_d;
   logic [DATA_W-1:0]   arr_wdata_q, arr_wdata_d;
   logic [NWORDS-1:0]   dec_onehot;
   logic                accept;

   // Gated by rst so the block never advertises readiness while held in reset.
   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   addr_onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
      .addr_i   (addr_q),
      .onehot_o (dec_onehot)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d     = ST_SETUP;
               addr_d      = req_addr;
               we_d        = req_we;
               wdata_d     = req_wdata;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         ST_SETUP:  state_d = ST_STROBE;
`ifdef MEM_CTRL_WVERIFY_EN
         ST_STROBE: state_d = (we_q == RW_WRITE) ? ST_VSETUP : ST_SAMPLE;
         ST_VSETUP:  state_d = ST_VSTROBE;
         ST_VSTROBE: state_d = ST_VSAMPLE;
         ST_VSAMPLE: begin
            rsp_rdata_d = arr_rdata;
            rsp_err_d   = (arr_rdata != wdata_q);
            state_d     = ST_RESP;
         end
`else
         ST_STROBE: state_d = (we_q == RW_WRITE) ? ST_RESP : ST_SAMPLE;
`endif
         ST_SAMPLE: begin
            rsp_rdata_d = arr_rdata;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Array-side outputs are registered from the next state; arr_rw only moves while
   // word_sel is low, and is held through RESP/IDLE.
   always_comb begin
      word_sel_d  = '0;
      arr_rw_d    = arr_rw_q;
      arr_wdata_d = arr_wdata_q;
      case (state_d)
         ST_SETUP, ST_STROBE: begin
            arr_rw_d    = we_d;
            arr_wdata_d = (we_d == RW_WRITE) ? wdata_d : '0;
         end
         ST_SAMPLE, ST_VSETUP, ST_VSTROBE, ST_VSAMPLE: arr_rw_d = RW_READ;
         default: ;
      endcase
      if (state_d == ST_STROBE || state_d == ST_SAMPLE ||
          state_d == ST_VSTROBE || state_d == ST_VSAMPLE) begin
         word_sel_d = dec_onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         word_sel_q  <= '0;
         arr_rw_q    <= RW_READ;
         arr_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         word_sel_q  <= word_sel_d;
         arr_rw_q    <= arr_rw_d;
         arr_wdata_q <= arr_wdata_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign word_sel  = word_sel_q;
   assign arr_rw    = arr_rw_q;
   assign arr_wdata = arr_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural 8x8 array, table vectors, corner sequences
// and random traffic checked against a word-level memory model.
module tb_mem_access_ctrl;

`ifdef MEM_CTRL_WVERIFY_EN
   localparam bit WVER = 1'b1;
`else
   localparam bit WVER = 1'b0;
`endif
   localparam int WR_LAT = WVER ? 6 : 3;
   localparam int RD_LAT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [2:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] word_sel;
   logic       arr_rw;
   logic [7:0] arr_wdata;
   logic [7:0] arr_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .word_sel  (word_sel),
      .arr_rw    (arr_rw),
      .arr_wdata (arr_wdata),
      .arr_rdata (arr_rdata)
   );

   // Behavioural array: selected word written on the clock edge when rw=1;
   // stuck0 forces bit 0 of every stored word low.
   logic [7:0] mem [8];
   logic       stuck0 = 1'b0;

   always @(posedge clk) begin
      for (int n = 0; n < 8; n++) begin
         if (word_sel[n] && arr_rw) mem[n] <= stuck0 ? (arr_wdata & 8'hFE) : arr_wdata;
      end
   end

   always_comb begin
      arr_rdata = '0;
      for (int n = 0; n < 8; n++) begin
         if (word_sel[n]) arr_rdata = arr_rdata | mem[n];
      end
   end

   // Reference model: what each word should hold, at word granularity.
   logic [7:0] ref_mem [8];

   typedef struct {
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] stored(input logic [7:0] wd);
      return stuck0 ? (wd & 8'hFE) : wd;
   endfunction

   // Present a request at a negedge and return at the negedge of cycle T+1.
   task automatic issue(input logic we, input logic [2:0] addr, input logic [7:0] wd);
      int w;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready before accept", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Starting at T+1, check the array sequence, response latency and contents.
   task automatic finish_txn(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                             input logic [7:0] exp_rd, input logic exp_err, input string nm);
      int lat;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         if (lat == 1) begin
            chk({nm, " setup word_sel"}, word_sel, 0);
            chk({nm, " setup arr_rw"}, arr_rw, we);
         end
         if (lat == 2) begin
            chk({nm, " strobe word_sel"}, word_sel, 32'(1) << addr);
            chk({nm, " strobe arr_rw"}, arr_rw, we);
            chk({nm, " strobe arr_wdata"}, arr_wdata, we ? wd : 8'h00);
         end
         if (lat == 3 && !we) begin
            chk({nm, " sample word_sel"}, word_sel, 32'(1) << addr);
            chk({nm, " sample arr_rw"}, arr_rw, 0);
         end
         @(negedge clk);
         lat++;
      end
      chk({nm, " rsp_valid"}, rsp_valid, 1);
      chk({nm, " latency"}, lat, we ? WR_LAT : RD_LAT);
      chk({nm, " rsp_rdata"}, rsp_rdata, exp_rd);
      chk({nm, " rsp_err"}, rsp_err, exp_err);
      chk({nm, " resp word_sel"}, word_sel, 0);
      chk({nm, " resp req_ready"}, req_ready, 0);
      $display("txn %s we=%0d addr=%0d wdata=%02h rdata=%02h err=%0d lat=%0d",
               nm, we, addr, wd, rsp_rdata, rsp_err, lat);
      @(negedge clk);
      chk({nm, " rsp_valid after handshake"}, rsp_valid, 0);
   endtask

   task automatic do_txn(input logic we, input logic [2:0] addr, input logic [7:0] wd, input string nm);
      logic [7:0] exp_rd;
      logic       exp_err;
      if (we) begin
         exp_rd     = WVER ? stored(wd) : 8'h00;
         exp_err    = WVER && (stored(wd) != wd);
         ref_mem[addr] = stored(wd);
      end else begin
         exp_rd  = ref_mem[addr];
         exp_err = 1'b0;
      end
      issue(we, addr, wd);
      finish_txn(we, addr, wd, exp_rd, exp_err, nm);
   endtask

   initial begin
      int w;

      tbl[0] = '{1'b1, 3'd3, 8'hA5, WVER ? 8'hA5 : 8'h00, 1'b0};
      tbl[1] = '{1'b0, 3'd3, 8'h00, 8'hA5, 1'b0};
      tbl[2] = '{1'b1, 3'd0, 8'h3C, WVER ? 8'h3C : 8'h00, 1'b0};
      tbl[3] = '{1'b1, 3'd7, 8'hFF, WVER ? 8'hFF : 8'h00, 1'b0};
      tbl[4] = '{1'b0, 3'd7, 8'h00, 8'hFF, 1'b0};
      tbl[5] = '{1'b0, 3'd0, 8'h00, 8'h3C, 1'b0};
      tbl[6] = '{1'b1, 3'd7, 8'h00, 8'h00, 1'b0};
      tbl[7] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b0};

      // Reset held for two edges, checked while still asserted and after release.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", req_ready, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset rsp_err", rsp_err, 0);
      chk("reset word_sel", word_sel, 0);
      chk("reset arr_rw", arr_rw, 0);
      chk("reset arr_wdata", arr_wdata, 0);
      rst = 1'b0;
      #1;
      chk("release req_ready", req_ready, 1);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wdata;
         issue(tbl[i].we, tbl[i].addr, tbl[i].wdata);
         finish_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
                    $sformatf("tbl%0d", i));
      end

      // Reset during STROBE of a write to addr 0.
      issue(1'b1, 3'd0, 8'h99);
      @(negedge clk);
      chk("rst-in-strobe word_sel", word_sel, 8'h01);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("after rst word_sel", word_sel, 0);
      chk("after rst rsp_valid", rsp_valid, 0);
      chk("after rst req_ready", req_ready, 1);
      $display("txn rst_in_strobe addr=0 aborted");
      @(negedge clk);

      for (int a = 0; a < 8; a++) do_txn(1'b1, 3'(a), 8'(8'h10 * a + 8'h5A), $sformatf("fill%0d", a));

      // Backpressure on a read of addr 7, with a second request waiting behind it.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 3'd7;
      req_wdata = 8'h00;
      chk("bp accept req_ready", req_ready, 1);
      @(negedge clk);
      req_we    = 1'b1;
      req_addr  = 3'd2;
      req_wdata = 8'h77;
      w = 1;
      while (rsp_valid !== 1'b1 && w < 20) begin
         chk("bp stalled req_ready", req_ready, 0);
         @(negedge clk);
         w++;
      end
      chk("bp read latency", w, RD_LAT);
      for (int i = 0; i < 5; i++) begin
         chk("bp rsp_valid held", rsp_valid, 1);
         chk("bp rsp_rdata held", rsp_rdata, ref_mem[7]);
         chk("bp req_ready low", req_ready, 0);
         @(negedge clk);
      end
      $display("txn bp_read addr=7 rdata=%02h held 5 cycles", rsp_rdata);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp idle after handshake", req_ready, 1);
      chk("bp rsp_valid dropped", rsp_valid, 0);
      @(negedge clk);
      req_valid = 1'b0;
      ref_mem[2] = 8'h77;
      finish_txn(1'b1, 3'd2, 8'h77, WVER ? 8'h77 : 8'h00, 1'b0, "bp_second");

`ifdef MEM_CTRL_WVERIFY_EN
      stuck0 = 1'b1;
      do_txn(1'b1, 3'd5, 8'h01, "stuck_verify");
      stuck0 = 1'b0;
      do_txn(1'b1, 3'd5, 8'h01, "unstuck_verify");
`endif

      for (int i = 0; i < 40; i++) begin
         logic       we;
         logic [2:0] addr;
         logic [7:0] wd;
         we   = 1'($urandom_range(0, 1));
         addr = 3'($urandom_range(0, 7));
         wd   = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_txn(we, addr, wd, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
